multicycle_control: RTL

Moore-style main control state machine that sequences the shared single-ALU, single-memory datapath of the 32-bit MIPS processor, one instruction at a time. Each cycle it drives the datapath select and enable lines for fetch, decode, execute, memory and write-back steps. It supports R-type, lw, sw, beq, addi and j. It waits on a memory-ready handshake for variable-latency memory, traps on unsupported opcodes, and counts retired instructions.

---
 rtl/multicycle_control.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back steps and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        irwrite,
  output logic        memtoreg,
  output logic        regdst,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  pcsource,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;
  logic        pcwrite, pcwritecond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; retire marks the last cycle of each instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_ILLEGAL;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:  state_d = S_ILLEGAL;
    endcase
    retired_d = retired_q + {31'd0, retire};
  end

  // Moore outputs; mem_ready only gates the fetch-completion strobes.
  always_comb begin
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:  begin iord = 1'b1; memread = 1'b1; end
      S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
      S_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsource    = 2'b01;
        pcwritecond = 1'b1;
      end
      S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP:   begin pcsource = 2'b10; pcwrite = 1'b1; end
      S_ILLEGAL: illegal = 1'b1;
      default:  illegal = 1'b0;
    endcase
  end

  assign pc_en   = pcwrite | (pcwritecond & zero);
  assign state   = state_q;
  assign retired = retired_q;

endmodule
